abs_seq: RTL and testbench
==========================

ABS_SEQ -- requirements
Module: abs_seq

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits (two's complement).
REQ-002 Parameter: CNT_W, 4, bit-counter width; SHALL equal ceil(log2(WIDTH)).
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  input  1  operand offered.
REQ-006 Port: in_ready  output  1  block can accept operand.
REQ-007 Port: in_data  input  WIDTH  operand.
REQ-008 Port: out_valid  output  1  result available.
REQ-009 Port: out_ready  input  1  consumer accepts result.
REQ-010 Port: out_data  output  WIDTH  absolute value of operand.
REQ-011 Port: out_neg  output  1  operand was negative (MSB=1).
REQ-012 Port: out_ovf  output  1  operand was most-negative value (0x8000 for WIDTH=16).

Function
REQ-013 States: IDLE, CHECK, NEGATE, DONE; exactly one active.
REQ-014 in_ready SHALL be 1 only in IDLE; accept = in_valid && in_ready; on accept latch in_data, go CHECK.
REQ-015 CHECK (one cycle): sign taken from latched MSB; nonnegative -> DONE, data unchanged, out_neg=0.
REQ-016 CHECK, negative: invert latched data, carry=1, counter=0, out_neg=1, go NEGATE.
REQ-017 NEGATE: one bit per cycle, LSB first: data[i] <= data[i] ^ carry; carry <= data[i] & carry; counter++.
REQ-018 NEGATE SHALL run exactly WIDTH cycles (no early exit); after bit WIDTH-1 go DONE.
REQ-019 out_ovf SHALL be 1 in DONE iff out_neg=1 and final out_data MSB=1; out_data then equals the operand unchanged.
REQ-020 Latency, accept edge to out_valid=1: 2 cycles nonnegative, WIDTH+2 cycles negative (18 for WIDTH=16).
REQ-021 DONE: out_valid=1, out_data/out_neg/out_ovf stable until out_valid && out_ready; then IDLE next edge.
REQ-022 out_valid SHALL be 0 in all states except DONE; out_data/out_neg/out_ovf SHALL be 0 outside DONE.
REQ-023 No new operand accepted in CHECK, NEGATE or DONE, even in the cycle out_ready is asserted (no bypass).
REQ-024 in_data changes while not in IDLE SHALL have no effect.

Reset
REQ-025 rst=1 at a rising edge SHALL force IDLE, data/carry/counter/flags=0, in_ready=1, out_valid=0, from any state.
REQ-026 rst mid-NEGATE or in DONE SHALL discard the operation; no out_valid pulse results from it.
REQ-027 rst has priority over accept and over output handshake in the same cycle.

Structure
REQ-028 Shared package SHALL hold state encoding constants (IDLE=0, CHECK=1, NEGATE=2, DONE=3) and default WIDTH.
REQ-029 Sign test SHALL instantiate the existing IsNeg gate module on the latched operand.
REQ-030 One sub-module: serial_inc_bit (1-bit half-adder cell: in bit, carry in -> sum, carry out); controller holds FSM, counter, shift/select.
REQ-031 Target size 120-400 lines RTL total.

Verification
REQ-032 in_data=0x0001 accepted -> out_valid after 2 cycles, out_data=0x0001, out_neg=0, out_ovf=0.
REQ-033 in_data=0xFFFF -> out_valid after 18 cycles, out_data=0x0001, out_neg=1, out_ovf=0; 0xA000 -> 0x6000, out_neg=1.
REQ-034 in_data=0x8000 -> out_data=0x8000, out_neg=1, out_ovf=1; 0x0000 -> 0x0000, all flags 0.
REQ-035 out_ready held 0 for 5 cycles in DONE -> out_valid and outputs stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-036 rst asserted 1 cycle at counter=7 of NEGATE for 0x8300 -> IDLE, all outputs 0; new 0x7020 -> 0x7020 after 2 cycles.
REQ-037 in_valid held 1 with changing in_data during NEGATE -> ignored; only first operand's result produced.

Source files
------------

// File: rtl/abs_seq_pkg.sv
// Shared constants and state encoding for the serial absolute-value block.
package abs_seq_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;
  localparam int unsigned CNT_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_NEGATE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage : abs_seq_pkg

// File: rtl/IsNeg.sv
// Sign test gate: flags a two's-complement operand whose MSB is set.
module IsNeg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] value,
  output logic             neg_c
);

  assign neg_c = value[WIDTH-1];

endmodule : IsNeg

// File: rtl/serial_inc_bit.sv
// One-bit half-adder cell used to ripple the +1 of a negation one bit per cycle.
module serial_inc_bit (
  input  logic bit_in,
  input  logic carry_in,
  output logic sum_c,
  output logic carry_c
);

  assign sum_c   = bit_in ^ carry_in;
  assign carry_c = bit_in & carry_in;

endmodule : serial_inc_bit

// File: rtl/abs_seq.sv
// Serial absolute value: invert then ripple +1 one bit per cycle, LSB first.
module abs_seq
  import abs_seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_neg,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_neg_q, out_neg_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept_c;
  logic             is_neg_c;
  logic             sum_c;
  logic             carry_out_c;
  logic             done_next_c;

  assign accept_c = in_valid && in_ready_q;

  IsNeg #(
    .WIDTH (WIDTH)
  ) u_is_neg (
    .value (data_q),
    .neg_c (is_neg_c)
  );

  serial_inc_bit u_inc_bit (
    .bit_in   (data_q[cnt_q]),
    .carry_in (carry_q),
    .sum_c    (sum_c),
    .carry_c  (carry_out_c)
  );

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          data_d  = in_data;
          carry_d = 1'b0;
          cnt_d   = '0;
          neg_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (is_neg_c) begin
          data_d  = ~data_q;
          carry_d = 1'b1;
          cnt_d   = '0;
          neg_d   = 1'b1;
          state_d = ST_NEGATE;
        end else begin
          neg_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_NEGATE: begin
        data_d[cnt_q] = sum_c;
        carry_d       = carry_out_c;
        cnt_d         = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          data_d  = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          neg_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    done_next_c = (state_d == ST_DONE);
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = done_next_c;
    out_data_d  = done_next_c ? data_d : '0;
    out_neg_d   = done_next_c && neg_d;
    out_ovf_d   = out_neg_d && data_d[WIDTH-1];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_neg_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_neg_q   <= out_neg_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_neg   = out_neg_q;
  assign out_ovf   = out_ovf_q;

endmodule : abs_seq

// File: tb/tb_abs_seq.sv
// Directed bench for abs_seq: latency, results, stall, reset abort, input masking.
module tb_abs_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_neg;
  logic             out_ovf;

  int n_pass;
  int n_total;

  abs_seq #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_neg   (out_neg),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Offer one operand and wait for its result; latency counts edges from the accept edge inclusive.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] opnd,
                        input logic [WIDTH-1:0] exp_data, input logic exp_neg,
                        input logic exp_ovf, input int exp_lat, input bit hold_valid,
                        input int stall);
    int lat;
    bit seen;
    chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = opnd;
    out_ready = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      lat++;
      if (!hold_valid) in_valid = 1'b0;
      in_data = WIDTH'($urandom);
      if (lat == 1) begin
        chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        chk({tag, " out_data busy"}, 32'(out_data), 32'd0);
      end
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    chk({tag, " result seen"}, 32'(seen), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " out_data"}, 32'(out_data), 32'(exp_data));
    chk({tag, " out_neg"}, 32'(out_neg), 32'(exp_neg));
    chk({tag, " out_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    for (int s = 0; s < stall; s++) begin
      tick();
      chk({tag, " stall valid"}, 32'(out_valid), 32'd1);
      chk({tag, " stall data"}, 32'(out_data), 32'(exp_data));
      chk({tag, " stall flags"}, 32'({out_neg, out_ovf}), 32'({exp_neg, exp_ovf}));
      chk({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " release valid"}, 32'(out_valid), 32'd0);
    chk({tag, " release in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " release outs"}, 32'({out_data, out_neg, out_ovf}), 32'd0);
  endtask

  initial begin
    bit bad;
    n_pass    = 0;
    n_total   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset outs", 32'({out_data, out_neg, out_ovf}), 32'd0);

    run_op("pos1",   16'h0001, 16'h0001, 1'b0, 1'b0, 2,  1'b0, 0);
    run_op("m1",     16'hFFFF, 16'h0001, 1'b1, 1'b0, 18, 1'b0, 0);
    run_op("a000",   16'hA000, 16'h6000, 1'b1, 1'b0, 18, 1'b0, 0);
    run_op("minneg", 16'h8000, 16'h8000, 1'b1, 1'b1, 18, 1'b0, 0);
    run_op("zero",   16'h0000, 16'h0000, 1'b0, 1'b0, 2,  1'b0, 0);
    run_op("maxpos", 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 2,  1'b0, 5);
    run_op("8001",   16'h8001, 16'h7FFF, 1'b1, 1'b0, 18, 1'b0, 5);
    run_op("hold",   16'hC123, 16'h3EDD, 1'b1, 1'b0, 18, 1'b1, 0);

    // Abort mid-negation: after accept edge, CHECK edge and 7 NEGATE edges the counter sits at 7.
    in_valid = 1'b1;
    in_data  = 16'h8300;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort outs", 32'({out_data, out_neg, out_ovf}), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    chk("abort no pulse", 32'(bad), 32'd0);
    run_op("post", 16'h7020, 16'h7020, 1'b0, 1'b0, 2, 1'b0, 0);

    // Reset wins over a simultaneous accept.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("rst prio in_ready", 32'(in_ready), 32'd1);
    chk("rst prio out_valid", 32'(out_valid), 32'd0);

    // Reset wins over the output handshake in DONE.
    in_valid = 1'b1;
    in_data  = 16'h0005;
    tick();
    in_valid = 1'b0;
    tick();
    chk("done valid", 32'(out_valid), 32'd1);
    rst       = 1'b1;
    out_ready = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    chk("done rst valid", 32'(out_valid), 32'd0);
    chk("done rst outs", 32'({out_data, out_neg, out_ovf}), 32'd0);
    chk("done rst in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_abs_seq
